fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32 core, directly upstream of the decode register and governed by the hazard unit's `stallF`, `stallD` and `flushD` outputs. It owns the PC register, issues requests on a pipelined instruction-memory handshake, and buffers responses in a small in-order fetch buffer. It delivers `instrD`, `pcD` and `pcplus4D` to decode. On a redirect it steers to the branch or jr target and discards wrong-path fetches that are still in flight.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 94 +++++++++
 rtl/fetch_stage.sv | 178 +++++++++++++++++
 tb/tb_fetch_stage.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: buffer slot layout and the canonical nop.
// Imported by fetch_buffer and fetch_stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_slot_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: slots allocated at grant, filled at response,
// popped by decode. Flush discards every slot.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     alloc_en,
  input  logic [31:0]              alloc_pc,
  input  logic                     fill_en,
  input  logic [31:0]              fill_data,
  input  logic                     pop_en,
  output fetch_slot_t              head,
  output logic [$clog2(DEPTH):0]   occ,
  output logic [$clog2(DEPTH):0]   pend
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_slot_t   slots_q [DEPTH];
  fetch_slot_t   slots_d [DEPTH];
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q, fill_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] pend_q, pend_d;

  assign head = slots_q[rd_ptr_q];
  assign occ  = occ_q;
  assign pend = pend_q;

  always_comb begin
    slots_d     = slots_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    pend_d      = pend_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_d[i].filled = 1'b0;
      end
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      pend_d      = '0;
    end else begin
      if (alloc_en) begin
        slots_d[alloc_ptr_q].pc     = alloc_pc;
        slots_d[alloc_ptr_q].instr  = NOP_INSTR;
        slots_d[alloc_ptr_q].filled = 1'b0;
        alloc_ptr_d = alloc_ptr_q + PW'(1);
      end
      if (fill_en) begin
        slots_d[fill_ptr_q].instr  = fill_data;
        slots_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d = fill_ptr_q + PW'(1);
      end
      // Pop after fill so a bypassed slot ends up empty.
      if (pop_en) begin
        slots_d[rd_ptr_q].filled = 1'b0;
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      occ_d  = occ_q + CW'(alloc_en) - CW'(pop_en);
      pend_d = pend_q + CW'(alloc_en) - CW'(fill_en);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_q[i] <= '0;
      end
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      pend_q      <= '0;
    end else begin
      slots_q     <= slots_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 fetch stage: PC, imem request/response, kill counter, decode reg.
// FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misaligned output.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  input  logic        jrE,
  input  logic [31:0] pcjrE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] kill_q, kill_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pcd_q, pcd_d;
  logic [31:0]   pcp4_q, pcp4_d;
  logic          valid_q, valid_d;

  fetch_slot_t   head;
  logic [CW-1:0] occ;
  logic [CW-1:0] pend;

  logic          grant;
  logic          redirect;
  logic [31:0]   target_raw;
  logic [31:0]   target;
  logic          drop;
  logic          fill_en;
  logic          alloc_en;
  logic          head_avail;
  logic          bypass;
  logic          pop_en;

  assign imem_addr = pc_q;
  assign imem_req  = reset_n & ~stallF &
    (({1'b0, occ} + {1'b0, kill_q}) < (CW + 1)'(BUF_DEPTH));
  assign grant     = imem_req & imem_gnt;

  // jr in E is older than a branch in D, so it wins.
  assign redirect   = jrE | (pcsrcD & ~stallD);
  assign target_raw = jrE ? pcjrE : pcbranchD;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q, mis_d;

  assign target           = align_pc(target_raw);
  assign fetch_misaligned = mis_q;

  always_comb begin
    mis_d = mis_q;
    if (redirect && (target_raw[1:0] != 2'b00)) begin
      mis_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
`else
  assign target = target_raw;
`endif

  assign drop       = imem_rvalid & (kill_q != '0);
  assign fill_en    = imem_rvalid & ~drop & (pend != '0);
  assign alloc_en   = grant & ~redirect;
  assign head_avail = occ != '0;
  assign bypass     = head_avail & ~head.filled & fill_en;
  assign pop_en     = ~redirect & ~flushD & ~stallD &
                      head_avail & (head.filled | bypass);

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .alloc_en  (alloc_en),
    .alloc_pc  (pc_q),
    .fill_en   (fill_en),
    .fill_data (imem_rdata),
    .pop_en    (pop_en),
    .head      (head),
    .occ       (occ),
    .pend      (pend)
  );

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = target;
    end else if (grant) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Everything still owed by memory on the old path must be dropped.
  always_comb begin
    kill_d = kill_q;
    if (redirect) begin
      kill_d = kill_q + pend + CW'(grant) - CW'(imem_rvalid);
    end else if (drop) begin
      kill_d = kill_q - CW'(1);
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (redirect) begin
      valid_d = 1'b0;
    end else if (flushD) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stallD) begin
      if (pop_en) begin
        instr_d = head.filled ? head.instr : imem_rdata;
        pcd_d   = head.pc;
        pcp4_d  = head.pc + 32'd4;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      kill_q  <= '0;
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'd0;
      pcp4_q  <= 32'd4;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign instrD   = instr_q;
  assign pcD      = pcd_q;
  assign pcplus4D = pcp4_q;
  assign validD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model plus a program-order
// stream model of what decode must see; directed redirect/stall cases.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stallF = 1'b0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        pcsrcD = 1'b0;
  logic [31:0] pcbranchD = 32'd0;
  logic        jrE = 1'b0;
  logic [31:0] pcjrE = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcplus4D;
  logic        validD;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  int errors = 0;
  int checks = 0;

  logic        mem_hold = 1'b0;
  logic [31:0] memq [$];

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stallF      (stallF),
    .stallD      (stallD),
    .flushD      (flushD),
    .pcsrcD      (pcsrcD),
    .pcbranchD   (pcbranchD),
    .jrE         (jrE),
    .pcjrE       (pcjrE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instrD      (instrD),
    .pcD         (pcD),
    .pcplus4D    (pcplus4D),
    .validD      (validD)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!validD && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, validD}, 32'd1);
  endtask

  // Memory: grants always, answers in order one cycle after the grant.
  always @(posedge clk) begin
    #2;
    if (!reset_n) begin
      memq.delete();
      imem_rvalid = 1'b0;
    end else if (!mem_hold && memq.size() != 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(memq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hBAD0_BAD0;
    end
  end

  // Stream model: decode must see pcs in program order from the last
  // redirect target, each word matching memory, none lost or repeated.
  logic [31:0] m_pc, exp_d;
  logic [31:0] s_instr, s_pc, s_pc4;
  logic        s_valid;
  logic        p_redir, p_flush, p_hold;

  always @(negedge clk) begin
    logic        redir;
    logic [31:0] tgt;
    if (!reset_n) begin
      m_pc    = RST_PC;
      exp_d   = RST_PC;
      p_redir = 1'b0;
      p_flush = 1'b0;
      p_hold  = 1'b0;
    end else begin
      chk("imem_addr", imem_addr, m_pc);
      if (p_redir) begin
        chk("valid_after_redirect", {31'd0, validD}, 32'd0);
      end else if (p_flush) begin
        chk("valid_after_flush", {31'd0, validD}, 32'd0);
        chk("nop_after_flush", instrD, NOP_INSTR);
      end else if (p_hold) begin
        chk("hold_instrD", instrD, s_instr);
        chk("hold_pcD", pcD, s_pc);
        chk("hold_pcplus4D", pcplus4D, s_pc4);
        chk("hold_validD", {31'd0, validD}, {31'd0, s_valid});
      end else if (validD) begin
        chk("stream_pcD", pcD, exp_d);
        chk("stream_instrD", instrD, mem_word(exp_d));
        chk("stream_pcplus4D", pcplus4D, exp_d + 32'd4);
        exp_d = exp_d + 32'd4;
      end
      redir = jrE | (pcsrcD & ~stallD);
      tgt   = jrE ? pcjrE : pcbranchD;
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      if (imem_req && imem_gnt) begin
        memq.push_back(imem_addr);
      end
      if (redir) begin
        m_pc  = tgt;
        exp_d = tgt;
      end else if (imem_req && imem_gnt) begin
        m_pc = m_pc + 32'd4;
      end
      p_redir = redir;
      p_flush = flushD & ~redir;
      p_hold  = stallD & ~flushD & ~redir;
      s_instr = instrD;
      s_pc    = pcD;
      s_pc4   = pcplus4D;
      s_valid = validD;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    cyc(2);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'd0, validD}, 32'd0);
    chk("rst_instr", instrD, 32'h0000_0013);
    chk("rst_pcD", pcD, 32'd0);
    chk("rst_pcplus4D", pcplus4D, 32'd4);

    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("req_after_release", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("valid_c1", {31'd0, validD}, 32'd0);
    @(negedge clk);
    chk("valid_c2", {31'd0, validD}, 32'd1);
    chk("pcD_c2", pcD, 32'h0);
    chk("instrD_c2", instrD, 32'hC0DE_0000);
    @(negedge clk);
    chk("pcD_c3", pcD, 32'h4);
    chk("valid_c3", {31'd0, validD}, 32'd1);

    // decode stall for three cycles
    cyc(1);
    stallD = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("req_when_full", {31'd0, imem_req}, 32'd0);
    cyc(1);
    cyc(1);
    stallD = 1'b0;
    cyc(6);

    // fetch stall
    stallF = 1'b1;
    @(negedge clk);
    chk("req_stallF", {31'd0, imem_req}, 32'd0);
    cyc(2);
    stallF = 1'b0;
    cyc(4);

    // branch with two requests outstanding
    mem_hold = 1'b1;
    cyc(1);
    pcsrcD    = 1'b1;
    pcbranchD = 32'h0000_0100;
    @(negedge clk);
    chk("req_two_outstanding", {31'd0, imem_req}, 32'd0);
    cyc(1);
    pcsrcD   = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    chk("branch_addr", imem_addr, 32'h0000_0100);
    chk("branch_valid_low", {31'd0, validD}, 32'd0);
    chk("req_while_killing", {31'd0, imem_req}, 32'd0);
    wait_valid(20, "branch_valid_timeout");
    chk("branch_first_pcD", pcD, 32'h0000_0100);
    cyc(3);

    // jr and branch together: jr wins
    jrE       = 1'b1;
    pcjrE     = 32'h0000_0200;
    pcsrcD    = 1'b1;
    pcbranchD = 32'h0000_0300;
    flushD    = 1'b1;
    cyc(1);
    jrE    = 1'b0;
    pcsrcD = 1'b0;
    flushD = 1'b0;
    @(negedge clk);
    chk("jr_addr", imem_addr, 32'h0000_0200);
    chk("jr_valid_low", {31'd0, validD}, 32'd0);
    wait_valid(20, "jr_valid_timeout");
    chk("jr_first_pcD", pcD, 32'h0000_0200);
    cyc(4);

    // redirect while a grant and a response share the cycle
    pcsrcD    = 1'b1;
    pcbranchD = 32'h0000_0400;
    @(negedge clk);
    chk("redir_rvalid_present", {31'd0, imem_rvalid}, 32'd1);
    chk("redir_grant_present", {31'd0, imem_req}, 32'd1);
    cyc(1);
    pcsrcD = 1'b0;
    @(negedge clk);
    chk("redir_addr", imem_addr, 32'h0000_0400);
    chk("redir_req_kill1", {31'd0, imem_req}, 32'd1);
    wait_valid(20, "redir_valid_timeout");
    chk("redir_first_pcD", pcD, 32'h0000_0400);
    cyc(3);

    // flushD alone
    flushD = 1'b1;
    cyc(1);
    flushD = 1'b0;
    cyc(6);

    // throughput in steady state
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (validD) cnt++;
    end
    chk("throughput", cnt, 32'd8);

    // pc+4 wrap
    cyc(1);
    pcsrcD    = 1'b1;
    pcbranchD = 32'hFFFF_FFF8;
    cyc(1);
    pcsrcD = 1'b0;
    wait_valid(20, "wrap_valid_timeout");
    chk("wrap_pcD0", pcD, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap_pcD1", pcD, 32'hFFFF_FFFC);
    chk("wrap_pcplus4D", pcplus4D, 32'h0);
    @(negedge clk);
    chk("wrap_pcD2", pcD, 32'h0);
    cyc(2);

`ifdef FETCH_MISALIGN_CHECK_EN
    pcsrcD    = 1'b1;
    pcbranchD = 32'h0000_0102;
    cyc(1);
    pcsrcD = 1'b0;
    @(negedge clk);
    chk("misalign_flag", {31'd0, fetch_misaligned}, 32'd1);
    chk("misalign_addr", imem_addr, 32'h0000_0100);
    wait_valid(20, "misalign_valid_timeout");
    chk("misalign_pcD", pcD, 32'h0000_0100);
    chk("misalign_sticky", {31'd0, fetch_misaligned}, 32'd1);
    cyc(2);
`endif

    // reset in the middle of traffic
    cyc(1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst2_valid", {31'd0, validD}, 32'd0);
    chk("rst2_addr", imem_addr, RST_PC);
    chk("rst2_req", {31'd0, imem_req}, 32'd0);
    chk("rst2_instr", instrD, 32'h0000_0013);
    cyc(2);
    reset_n = 1'b1;
    wait_valid(20, "rst2_valid_timeout");
    chk("rst2_first_pcD", pcD, RST_PC);
    cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
